// File: rtl/pipe_ctrl_decode.sv
// Control unit for the 5-stage ARM-subset core: decodes the ID instruction and pipes EX/MEM/WB controls.
// ID controls are combinational; EX +1, MEM +2, reg_write_wr +2+WB_DELAY cycles; stall/flush inject an EX bubble.
module pipe_ctrl_decode #(
  parameter int ALUOP_W  = 3,
  parameter int WB_DELAY = 1,
  parameter int COND_EN  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        instruction,
  input  logic               stall,
  input  logic               flush,
  input  logic               negative,
  input  logic               zero,
  input  logic               carryout,
  input  logic               overflow,
  input  logic               cbz_zero,
  output logic               reg2loc,
  output logic               alu_src,
  output logic               val_select,
  output logic               br_taken,
  output logic               uncond_br,
  output logic               illegal,
  output logic [ALUOP_W-1:0] alu_op_ex,
  output logic               shift_select_ex,
  output logic               direction_ex,
  output logic               mem_to_reg_mem,
  output logic               mem_write_mem,
  output logic               which_to_reg_mem,
  output logic               reg_write_wr,
  output logic [3:0]         flags_q
);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b011);

  typedef struct packed {
    logic               reg2loc;
    logic               alu_src;
    logic               val_select;
    logic               br_taken;
    logic               uncond_br;
    logic               illegal;
    logic [ALUOP_W-1:0] alu_op;
    logic               shift_select;
    logic               direction;
    logic               mem_to_reg;
    logic               mem_write;
    logic               which_to_reg;
    logic               reg_write;
    logic               set_flags;
  } dec_t;

  typedef struct packed {
    logic               vld;
    logic [ALUOP_W-1:0] alu_op;
    logic               shift_select;
    logic               direction;
    logic               mem_to_reg;
    logic               mem_write;
    logic               which_to_reg;
    logic               reg_write;
    logic               set_flags;
  } ex_t;

  typedef struct packed {
    logic vld;
    logic mem_to_reg;
    logic mem_write;
    logic which_to_reg;
    logic reg_write;
  } mem_t;

  dec_t                dec;
  ex_t                 ex_d, ex_q;
  mem_t                mem_d, mem_q;
  logic [WB_DELAY-1:0] wb_we_q;
  logic [3:0]          flags_d;
  logic                fwd;
  logic                flag_n, flag_z, flag_v;
  logic                cond_legal, cond_true;
  logic                bubble;
  logic                unused_bits;

  assign unused_bits = ^instruction[9:5];

  // A flag-setter in EX has not written flags_q yet, so branches must see its live flags.
  assign fwd    = ex_q.vld && ex_q.set_flags;
  assign flag_n = fwd ? negative : flags_q[3];
  assign flag_z = fwd ? zero     : flags_q[2];
  assign flag_v = fwd ? overflow : flags_q[0];

  always_comb begin
    cond_legal = 1'b0;
    cond_true  = 1'b0;
    case (instruction[3:0])
      4'b0000: begin cond_legal = (COND_EN != 0); cond_true = flag_z;                         end
      4'b0001: begin cond_legal = (COND_EN != 0); cond_true = !flag_z;                        end
      4'b1010: begin cond_legal = (COND_EN != 0); cond_true = (flag_n == flag_v);             end
      4'b1011: begin cond_legal = 1'b1;           cond_true = (flag_n != flag_v);             end
      4'b1100: begin cond_legal = (COND_EN != 0); cond_true = !flag_z && (flag_n == flag_v);  end
      4'b1101: begin cond_legal = (COND_EN != 0); cond_true = flag_z || (flag_n != flag_v);   end
      default: begin cond_legal = 1'b0;           cond_true = 1'b0;                           end
    endcase
  end

  always_comb begin
    dec = '0;
    if (instruction[31:22] == 10'b1001000100) begin
      dec.alu_src    = 1'b1;
      dec.val_select = 1'b1;
      dec.reg_write  = 1'b1;
      dec.alu_op     = ALU_ADD;
    end else if (instruction[31:21] == 11'b10101011000 && instruction[15:10] == 6'd0) begin
      dec.reg2loc   = 1'b1;
      dec.reg_write = 1'b1;
      dec.alu_op    = ALU_ADD;
      dec.set_flags = 1'b1;
    end else if (instruction[31:21] == 11'b11101011000 && instruction[15:10] == 6'd0) begin
      dec.reg2loc   = 1'b1;
      dec.reg_write = 1'b1;
      dec.alu_op    = ALU_SUB;
      dec.set_flags = 1'b1;
    end else if (instruction[31:26] == 6'b000101) begin
      dec.br_taken  = 1'b1;
      dec.uncond_br = 1'b1;
    end else if (instruction[31:24] == 8'b01010100 && !instruction[4] && cond_legal) begin
      dec.br_taken = cond_true;
    end else if (instruction[31:24] == 8'b10110100) begin
      dec.br_taken = cbz_zero;
    end else if (instruction[31:24] == 8'b10110101) begin
      dec.br_taken = !cbz_zero;
    end else if (instruction[31:21] == 11'b11111000010 && instruction[11:10] == 2'b00) begin
      dec.alu_src    = 1'b1;
      dec.mem_to_reg = 1'b1;
      dec.reg_write  = 1'b1;
      dec.alu_op     = ALU_ADD;
    end else if (instruction[31:21] == 11'b11111000000 && instruction[11:10] == 2'b00) begin
      dec.alu_src   = 1'b1;
      dec.mem_write = 1'b1;
      dec.alu_op    = ALU_ADD;
    end else if (instruction[31:22] == 10'b1101001101 && instruction[20:16] == 5'd0) begin
      // bit 21 distinguishes LSL (1) from LSR (0); direction is 1 for a right shift
      dec.reg_write    = 1'b1;
      dec.shift_select = 1'b1;
      dec.which_to_reg = 1'b1;
      dec.direction    = !instruction[21];
    end else if (instruction[31:21] == 11'b10011011000 && instruction[15:10] == 6'h1F) begin
      dec.reg2loc      = 1'b1;
      dec.reg_write    = 1'b1;
      dec.which_to_reg = 1'b1;
    end else begin
      dec.illegal = 1'b1;
    end
  end

  assign bubble = stall || flush || dec.illegal;

  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.vld          = 1'b1;
      ex_d.alu_op       = dec.alu_op;
      ex_d.shift_select = dec.shift_select;
      ex_d.direction    = dec.direction;
      ex_d.mem_to_reg   = dec.mem_to_reg;
      ex_d.mem_write    = dec.mem_write;
      ex_d.which_to_reg = dec.which_to_reg;
      ex_d.reg_write    = dec.reg_write;
      ex_d.set_flags    = dec.set_flags;
    end
  end

  always_comb begin
    mem_d              = '0;
    mem_d.vld          = ex_q.vld;
    mem_d.mem_to_reg   = ex_q.vld && ex_q.mem_to_reg;
    mem_d.mem_write    = ex_q.vld && ex_q.mem_write;
    mem_d.which_to_reg = ex_q.vld && ex_q.which_to_reg;
    mem_d.reg_write    = ex_q.vld && ex_q.reg_write;
  end

  assign flags_d = fwd ? {negative, zero, carryout, overflow} : flags_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_we_q <= '0;
      flags_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_we_q <= WB_DELAY'({wb_we_q, mem_q.vld && mem_q.reg_write});
      flags_q <= flags_d;
    end
  end

  // ID outputs are forced low while reset is asserted so the whole block reads idle.
  assign reg2loc    = reset_n && dec.reg2loc;
  assign alu_src    = reset_n && dec.alu_src;
  assign val_select = reset_n && dec.val_select;
  assign illegal    = reset_n && dec.illegal;
  assign br_taken   = reset_n && !stall && !flush && dec.br_taken;
  assign uncond_br  = reset_n && !stall && !flush && dec.uncond_br;

  assign alu_op_ex        = ex_q.alu_op;
  assign shift_select_ex  = ex_q.shift_select;
  assign direction_ex     = ex_q.direction;
  assign mem_to_reg_mem   = mem_q.mem_to_reg;
  assign mem_write_mem    = mem_q.mem_write;
  assign which_to_reg_mem = mem_q.which_to_reg;
  assign reg_write_wr     = wb_we_q[WB_DELAY-1];

endmodule

// File: tb/tb_pipe_ctrl_decode.sv
// Directed bench for pipe_ctrl_decode: default instance plus a COND_EN=0, WB_DELAY=3 instance on shared inputs.
module tb_pipe_ctrl_decode;

  localparam logic [31:0] I_ADDI = 32'h91000421;
  localparam logic [31:0] I_SUBS = 32'hEB020020;
  localparam logic [31:0] I_B    = 32'h14000004;
  localparam logic [31:0] I_BEQ  = 32'h54000040;
  localparam logic [31:0] I_BNE  = 32'h54000041;
  localparam logic [31:0] I_BGE  = 32'h5400004A;
  localparam logic [31:0] I_BLT  = 32'h5400004B;
  localparam logic [31:0] I_BGT  = 32'h5400004C;
  localparam logic [31:0] I_BLE  = 32'h5400004D;
  localparam logic [31:0] I_BCS  = 32'h54000042;
  localparam logic [31:0] I_BB4  = 32'h54000050;
  localparam logic [31:0] I_CBZ  = 32'hB4000041;
  localparam logic [31:0] I_CBNZ = 32'hB5000041;
  localparam logic [31:0] I_LDUR = 32'hF8400041;
  localparam logic [31:0] I_STUR = 32'hF8000041;
  localparam logic [31:0] I_LSR  = 32'hD3400841;
  localparam logic [31:0] I_MUL  = 32'h9B027C20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instruction = '0;
  logic        stall = 1'b0, flush = 1'b0, cbz_zero = 1'b0;
  logic        negative = 1'b0, zero = 1'b0, carryout = 1'b0, overflow = 1'b0;

  logic       reg2loc, alu_src, val_select, br_taken, uncond_br, illegal;
  logic [2:0] alu_op_ex;
  logic       shift_select_ex, direction_ex, mem_to_reg_mem, mem_write_mem, which_to_reg_mem, reg_write_wr;
  logic [3:0] flags_q;

  logic       reg2loc1, alu_src1, val_select1, br_taken1, uncond_br1, illegal1;
  logic [2:0] alu_op_ex1;
  logic       shift_select_ex1, direction_ex1, mem_to_reg_mem1, mem_write_mem1, which_to_reg_mem1, reg_write_wr1;
  logic [3:0] flags_q1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl_decode #(.ALUOP_W(3), .WB_DELAY(1), .COND_EN(1)) u0 (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .stall(stall), .flush(flush),
    .negative(negative), .zero(zero), .carryout(carryout), .overflow(overflow), .cbz_zero(cbz_zero),
    .reg2loc(reg2loc), .alu_src(alu_src), .val_select(val_select), .br_taken(br_taken),
    .uncond_br(uncond_br), .illegal(illegal), .alu_op_ex(alu_op_ex), .shift_select_ex(shift_select_ex),
    .direction_ex(direction_ex), .mem_to_reg_mem(mem_to_reg_mem), .mem_write_mem(mem_write_mem),
    .which_to_reg_mem(which_to_reg_mem), .reg_write_wr(reg_write_wr), .flags_q(flags_q)
  );

  pipe_ctrl_decode #(.ALUOP_W(3), .WB_DELAY(3), .COND_EN(0)) u1 (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .stall(stall), .flush(flush),
    .negative(negative), .zero(zero), .carryout(carryout), .overflow(overflow), .cbz_zero(cbz_zero),
    .reg2loc(reg2loc1), .alu_src(alu_src1), .val_select(val_select1), .br_taken(br_taken1),
    .uncond_br(uncond_br1), .illegal(illegal1), .alu_op_ex(alu_op_ex1), .shift_select_ex(shift_select_ex1),
    .direction_ex(direction_ex1), .mem_to_reg_mem(mem_to_reg_mem1), .mem_write_mem(mem_write_mem1),
    .which_to_reg_mem(which_to_reg_mem1), .reg_write_wr(reg_write_wr1), .flags_q(flags_q1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    instruction = '0;
    stall = 1'b0;
    flush = 1'b0;
    {negative, zero, carryout, overflow} = 4'b0000;
    repeat (n) step();
  endtask

  task automatic test_reset();
    logic [15:0] all_out;
    #1;
    all_out = {reg2loc, alu_src, val_select, br_taken, uncond_br, illegal, alu_op_ex, shift_select_ex,
               direction_ex, mem_to_reg_mem, mem_write_mem, which_to_reg_mem, reg_write_wr};
    total++; if (all_out !== 16'h0 || flags_q !== 4'h0) begin bad++; $display("FAIL reset_cold got=%h/%h exp=0/0", all_out, flags_q); end
    repeat (2) step();
    reset_n = 1'b1;
    instruction = I_SUBS;
    {negative, zero, carryout, overflow} = 4'b1000;
    step();
    total++; if (alu_op_ex !== 3'b011) begin bad++; $display("FAIL reset_subs_in_ex got=%h exp=3", alu_op_ex); end
    instruction = I_SUBS;
    reset_n = 1'b0;
    #1;
    all_out = {reg2loc, alu_src, val_select, br_taken, uncond_br, illegal, alu_op_ex, shift_select_ex,
               direction_ex, mem_to_reg_mem, mem_write_mem, which_to_reg_mem, reg_write_wr};
    total++; if (all_out !== 16'h0) begin bad++; $display("FAIL reset_midflight got=%h exp=0", all_out); end
    repeat (2) step();
    total++; if (flags_q !== 4'h0) begin bad++; $display("FAIL reset_flags_hold got=%h exp=0", flags_q); end
    instruction = '0;
    {negative, zero, carryout, overflow} = 4'b0000;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (reg_write_wr !== 1'b0) begin bad++; $display("FAIL reset_no_write[%0d] got=%b exp=0", i, reg_write_wr); end
    end
    total++; if (flags_q !== 4'h0) begin bad++; $display("FAIL reset_flags_after got=%h exp=0", flags_q); end
  endtask

  task automatic test_blt_forward();
    idle(3);
    instruction = I_SUBS;
    {negative, zero, carryout, overflow} = 4'b1000;
    #1;
    total++; if (reg2loc !== 1'b1) begin bad++; $display("FAIL subs_reg2loc got=%b exp=1", reg2loc); end
    step();
    total++; if (alu_op_ex !== 3'b011) begin bad++; $display("FAIL subs_aluop got=%h exp=3", alu_op_ex); end
    total++; if (flags_q !== 4'b0000) begin bad++; $display("FAIL blt_flags_pre got=%b exp=0000", flags_q); end
    instruction = I_BLT;
    #1;
    total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL blt_forward got=%b exp=1", br_taken); end
    total++; if (uncond_br !== 1'b0) begin bad++; $display("FAIL blt_uncond got=%b exp=0", uncond_br); end
    total++; if (br_taken1 !== 1'b1) begin bad++; $display("FAIL blt_forward_u1 got=%b exp=1", br_taken1); end
    step();
    total++; if (flags_q !== 4'b1000) begin bad++; $display("FAIL blt_flags_post got=%b exp=1000", flags_q); end
  endtask

  task automatic test_beq_stored();
    idle(2);
    instruction = I_SUBS;
    {negative, zero, carryout, overflow} = 4'b0100;
    step();
    instruction = I_ADDI;
    step();
    total++; if (flags_q !== 4'b0100) begin bad++; $display("FAIL beq_flags got=%b exp=0100", flags_q); end
    {negative, zero, carryout, overflow} = 4'b1001;
    instruction = I_BEQ; #1;
    total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL beq_stored got=%b exp=1", br_taken); end
    instruction = I_BGT; #1;
    total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL bgt_stored got=%b exp=0", br_taken); end
    instruction = I_BLE; #1;
    total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL ble_stored got=%b exp=1", br_taken); end
    instruction = I_BNE; #1;
    total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL bne_stored got=%b exp=0", br_taken); end
    instruction = I_BGE; #1;
    total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL bge_stored got=%b exp=1", br_taken); end
    step();
    total++; if (flags_q !== 4'b0100) begin bad++; $display("FAIL flags_hold got=%b exp=0100", flags_q); end
  endtask

  task automatic test_ldur_stall();
    idle(5);
    instruction = I_LDUR;
    stall = 1'b1;
    #1;
    total++; if (alu_src !== 1'b1) begin bad++; $display("FAIL stall_id_alu_src got=%b exp=1", alu_src); end
    step();
    total++; if (alu_op_ex !== 3'b000) begin bad++; $display("FAIL stall_bubble_aluop got=%h exp=0", alu_op_ex); end
    stall = 1'b0;
    step();
    total++; if (alu_op_ex !== 3'b010) begin bad++; $display("FAIL ldur_aluop got=%h exp=2", alu_op_ex); end
    total++; if (mem_to_reg_mem !== 1'b0) begin bad++; $display("FAIL stall_bubble_mem got=%b exp=0", mem_to_reg_mem); end
    instruction = '0;
    step();
    total++; if (mem_to_reg_mem !== 1'b1) begin bad++; $display("FAIL ldur_mem_to_reg got=%b exp=1", mem_to_reg_mem); end
    total++; if (reg_write_wr !== 1'b0) begin bad++; $display("FAIL stall_slot_wr got=%b exp=0", reg_write_wr); end
    step();
    total++; if (reg_write_wr !== 1'b1) begin bad++; $display("FAIL ldur_wr got=%b exp=1", reg_write_wr); end
    total++; if (reg_write_wr1 !== 1'b0) begin bad++; $display("FAIL ldur_wr_d3_early0 got=%b exp=0", reg_write_wr1); end
    step();
    total++; if (reg_write_wr !== 1'b0) begin bad++; $display("FAIL ldur_wr_after got=%b exp=0", reg_write_wr); end
    total++; if (reg_write_wr1 !== 1'b0) begin bad++; $display("FAIL ldur_wr_d3_early1 got=%b exp=0", reg_write_wr1); end
    step();
    total++; if (reg_write_wr1 !== 1'b1) begin bad++; $display("FAIL ldur_wr_d3 got=%b exp=1", reg_write_wr1); end
  endtask

  task automatic test_back_to_back();
    idle(5);
    instruction = I_STUR; #1;
    total++; if ({reg2loc, alu_src, val_select} !== 3'b010) begin bad++; $display("FAIL stur_id got=%b exp=010", {reg2loc, alu_src, val_select}); end
    step();
    total++; if ({alu_op_ex, shift_select_ex} !== 4'b0100) begin bad++; $display("FAIL stur_ex got=%b exp=0100", {alu_op_ex, shift_select_ex}); end
    instruction = I_LSR;
    step();
    total++; if (mem_write_mem !== 1'b1) begin bad++; $display("FAIL stur_mem_write got=%b exp=1", mem_write_mem); end
    total++; if ({alu_op_ex, shift_select_ex, direction_ex} !== 5'b00011) begin bad++; $display("FAIL lsr_ex got=%b exp=00011", {alu_op_ex, shift_select_ex, direction_ex}); end
    instruction = I_MUL; #1;
    total++; if ({reg2loc, alu_src, val_select} !== 3'b100) begin bad++; $display("FAIL mul_id got=%b exp=100", {reg2loc, alu_src, val_select}); end
    step();
    total++; if ({mem_write_mem, which_to_reg_mem, reg_write_wr} !== 3'b010) begin bad++; $display("FAIL b2b_c3 got=%b exp=010", {mem_write_mem, which_to_reg_mem, reg_write_wr}); end
    total++; if ({shift_select_ex, direction_ex} !== 2'b00) begin bad++; $display("FAIL mul_ex got=%b exp=00", {shift_select_ex, direction_ex}); end
    instruction = I_ADDI; #1;
    total++; if ({reg2loc, alu_src, val_select} !== 3'b011) begin bad++; $display("FAIL addi_id got=%b exp=011", {reg2loc, alu_src, val_select}); end
    step();
    total++; if ({which_to_reg_mem, reg_write_wr} !== 2'b11) begin bad++; $display("FAIL b2b_c4 got=%b exp=11", {which_to_reg_mem, reg_write_wr}); end
    instruction = '0;
    step();
    total++; if ({which_to_reg_mem, reg_write_wr} !== 2'b01) begin bad++; $display("FAIL b2b_c5 got=%b exp=01", {which_to_reg_mem, reg_write_wr}); end
    step();
    total++; if (reg_write_wr !== 1'b1) begin bad++; $display("FAIL b2b_addi_wr got=%b exp=1", reg_write_wr); end
    step();
    total++; if (reg_write_wr !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%b exp=0", reg_write_wr); end
  endtask

  task automatic test_branches();
    idle(1);
    instruction = I_CBNZ; cbz_zero = 1'b0; #1;
    total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL cbnz_taken got=%b exp=1", br_taken); end
    cbz_zero = 1'b1; #1;
    total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL cbnz_not got=%b exp=0", br_taken); end
    cbz_zero = 1'b0; flush = 1'b1; #1;
    total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL cbnz_flush got=%b exp=0", br_taken); end
    flush = 1'b0; stall = 1'b1; #1;
    total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL cbnz_stall got=%b exp=0", br_taken); end
    stall = 1'b0; instruction = I_CBZ; cbz_zero = 1'b1; #1;
    total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL cbz_taken got=%b exp=1", br_taken); end
    instruction = I_B; cbz_zero = 1'b0; #1;
    total++; if ({br_taken, uncond_br} !== 2'b11) begin bad++; $display("FAIL b_uncond got=%b exp=11", {br_taken, uncond_br}); end
    stall = 1'b1; flush = 1'b1; #1;
    total++; if ({br_taken, uncond_br} !== 2'b00) begin bad++; $display("FAIL b_stall_flush got=%b exp=00", {br_taken, uncond_br}); end
    idle(1);
  endtask

  task automatic test_illegal();
    idle(5);
    instruction = 32'hFFFFFFFF; #1;
    total++; if ({illegal, reg2loc, alu_src, val_select, br_taken} !== 5'b10000) begin bad++; $display("FAIL ffff_id got=%b exp=10000", {illegal, reg2loc, alu_src, val_select, br_taken}); end
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if ({alu_op_ex, mem_write_mem, reg_write_wr} !== 5'b0) begin bad++; $display("FAIL ffff_pipe[%0d] got=%b exp=00000", i, {alu_op_ex, mem_write_mem, reg_write_wr}); end
    end
    instruction = I_BCS; #1;
    total++; if ({illegal, br_taken} !== 2'b10) begin bad++; $display("FAIL bcs_illegal got=%b exp=10", {illegal, br_taken}); end
    instruction = I_BB4; #1;
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL bcond_bit4 got=%b exp=1", illegal); end
    instruction = I_BEQ; #1;
    total++; if ({illegal, illegal1} !== 2'b01) begin bad++; $display("FAIL beq_cond_en got=%b exp=01", {illegal, illegal1}); end
    instruction = I_BLT; #1;
    total++; if (illegal1 !== 1'b0) begin bad++; $display("FAIL blt_cond_en0 got=%b exp=0", illegal1); end
    instruction = I_ADDI; #1;
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL addi_legal got=%b exp=0", illegal); end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_blt_forward();
    test_beq_stored();
    test_ldur_stall();
    test_back_to_back();
    test_branches();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_decode.md
Name: pipe_ctrl_decode

Overview:
- Parametrised next-generation control unit for the 5-stage pipelined ARM-subset core.
- Decodes the ID-stage instruction into ID-stage controls, and pipes EX/MEM/WB controls with per-stage valid bits.
- Holds an architectural NZCV flag register with EX-stage flag forwarding, and resolves the full B.cond set.
- Adds stall/flush bubble insertion, CBNZ, an illegal-opcode flag and a configurable WB delay.

Parameters:
ALUOP_W, 3, ALU op width (≥3); ALU codes zero-extended.
WB_DELAY, 1, register stages from MEM to reg_write_wr (1..4).
COND_EN, 1, 1 = EQ/NE/GE/LT/GT/LE supported; 0 = LT only, other conds illegal.

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
instruction  in  32  ID-stage instruction
stall  in  1  hold ID, inject bubble into EX
flush  in  1  squash ID instruction
negative,zero,carryout,overflow  in  1 each  ALU flags of instruction currently in EX
cbz_zero  in  1  ID-stage Rt==0
reg2loc,alu_src,val_select  out  1 each  ID-stage controls
br_taken,uncond_br  out  1 each  ID-stage branch controls
illegal  out  1  ID instruction undecodable
alu_op_ex  out  ALUOP_W  EX ALU op
shift_select_ex,direction_ex  out  1 each  EX shifter/mult controls
mem_to_reg_mem,mem_write_mem,which_to_reg_mem  out  1 each  MEM controls
reg_write_wr  out  1  WB write enable
flags_q  out  4  stored {N,Z,C,V}

Behaviour:
- All undefined controls drive 0, never X. Reset asserts asynchronously: every stage register, valid bit and flags_q = 0, so all outputs are 0.
- Decode, first match wins:
  - ADDI: [31:22]=1001000100 → alu_src=1, val_select=1, reg_write, aluop 010.
  - ADDS: [31:21]=10101011000, shamt=0 → reg2loc=1, reg_write, aluop 010, sets flags.
  - SUBS: [31:21]=11101011000, shamt=0 → as ADDS with aluop 011.
  - B: [31:26]=000101 → br_taken=uncond_br=1.
  - B.cond: [31:24]=01010100, [4]=0, cond=[3:0] → br_taken=cond result.
  - CBZ: [31:24]=10110100 → br_taken=cbz_zero.
  - CBNZ: [31:24]=10110101 → br_taken=!cbz_zero.
  - LDUR: [31:21]=11111000010, [11:10]=00 → alu_src=1, mem_to_reg=1, reg_write, aluop 010.
  - STUR: [31:21]=11111000000, [11:10]=00 → alu_src=1, mem_write, aluop 010.
  - LSL/LSR: 11010011011/11010011010, Rm=0 → reg_write, shift_select=1, which_to_reg=1, direction 0/1.
  - MUL: 10011011000, shamt=0x1F → reg2loc=1, reg_write, shift_select=0, which_to_reg=1.
  - Anything else → illegal=1, bubble.
- Conditions: EQ 0000 → Z; NE 0001 → !Z; GE 1010 → N==V; LT 1011 → N!=V; GT 1100 → !Z&&N==V; LE 1101 → Z||N!=V. Other codes, or non-LT when COND_EN=0 → illegal.
- Flag source: if a valid flag-setter is in EX this cycle, use the live flag inputs (forwarding); else use flags_q.
- flags_q <= {N,Z,C,V} at each clk edge where a valid flag-setter is in EX; otherwise hold.
- Pipeline timing:
  - ID→EX, EX→MEM and MEM→WB each advance every clock.
  - alu_op_ex, shift_select_ex and direction_ex are valid 1 cycle after decode.
  - MEM outputs are valid 2 cycles after decode.
  - reg_write_wr is valid 2+WB_DELAY cycles after decode.
- stall=1 or flush=1:
  - br_taken and uncond_br are forced 0.
  - EX register loads a bubble: valid=0, reg_write=0, mem_write=0, no flag set, other fields 0.
  - Downstream stages keep advancing.
  - ID-stage combinational outputs other than branch still reflect instruction.
- Simultaneous stall and flush: same as either one.
- Illegal instruction: enters EX as a bubble.
- reset_n asserted mid-flight: in-flight writes vanish immediately; first post-reset instruction behaves as from cold start.

Test Plan:
- Reset with SUBS in EX → all outputs 0 during reset; no write on release; flags_q=0.
- SUBS, then B.LT next cycle with live N=1,V=0 → br_taken=1 in the B.LT cycle; flags_q=1000 one edge later.
- SUBS with N=0,Z=1,V=0, then ADDI, then B.EQ → B.EQ uses flags_q=0100, br_taken=1; B.GT on the same flags → 0.
- LDUR with stall=1 for one cycle → EX gets a bubble (reg_write_wr stays 0 at the expected slot); next cycle LDUR issues normally and reg_write_wr=1 at cycle 2+WB_DELAY.
- CBNZ with cbz_zero=0 → br_taken=1; with flush=1 → br_taken=0.
- Instruction 0xFFFFFFFF → illegal=1, no downstream writes; with COND_EN=0, B.EQ → illegal=1.
